// File: rtl/mmff_group.sv
// rtl/mmff_group.sv - multi-mode flop group with per-channel config chain and scan chain
module mmff_group #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             global_reset_n,
    input  logic             config_enable,
    input  logic             ccff_head,
    output logic             ccff_tail,
    output logic             cfg_loaded,
    input  logic             scan_mode,
    input  logic             scan_enable,
    input  logic             scan_in,
    output logic             scan_out,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] q_out
);
    localparam int CFG_LEN = 5 * WIDTH;
    localparam int CNT_W   = $clog2(CFG_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_LEN);

    logic [CFG_LEN-1:0] cfg_q, cfg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cen_q;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH:0]     scan_sh;
    logic [4:0]         mode [WIDTH];

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            cfg_q <= '0;
            cnt_q <= '0;
            cen_q <= 1'b0;
            q_q   <= '0;
        end else begin
            cfg_q <= cfg_d;
            cnt_q <= cnt_d;
            cen_q <= config_enable;
            q_q   <= q_d;
        end
    end

    // cfg[0] takes the head bit, so the first bit shifted in ends up at the tail.
    always_comb begin
        cfg_d = cfg_q;
        cnt_d = cnt_q;
        if (config_enable) begin
            cfg_d = {cfg_q[CFG_LEN-2:0], ccff_head};
            if (!cen_q)
                cnt_d = CNT_W'(1);
            else if (cnt_q != CNT_FULL)
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign ccff_tail  = cfg_q[CFG_LEN-1];
    assign cfg_loaded = (cnt_q == CNT_FULL);
    assign scan_sh    = {q_q, scan_in};

    always_comb begin
        q_d   = q_q;
        q_out = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mode[i] = scan_mode ? 5'b00000 : cfg_q[5*i +: 5];
            if (config_enable)
                q_d[i] = q_q[i];
            else if (scan_enable)
                q_d[i] = scan_sh[i];
            else if (mode[i][1] && r[i])
                q_d[i] = mode[i][2];
            else if (mode[i][0] && !e[i])
                q_d[i] = q_q[i];
            else
                q_d[i] = d[i];
            q_out[i] = mode[i][4] ^ (mode[i][3] ? d[i] : q_q[i]);
        end
    end

    // Scan observes the raw flop, independent of bypass/invert.
    assign scan_out = q_q[WIDTH-1];

endmodule

// File: tb/tb_mmff_group.sv
// tb/tb_mmff_group.sv - directed self-checking bench for mmff_group
module tb_mmff_group;
    localparam int WIDTH   = 4;
    localparam int CFG_LEN = 5 * WIDTH;

    logic             clock = 1'b0;
    logic             global_reset_n;
    logic             config_enable;
    logic             ccff_head;
    logic             ccff_tail;
    logic             cfg_loaded;
    logic             scan_mode;
    logic             scan_enable;
    logic             scan_in;
    logic             scan_out;
    logic [WIDTH-1:0] d, r, e;
    logic [WIDTH-1:0] q_out;

    int vectors     = 0;
    int miscompares = 0;

    logic [CFG_LEN-1:0] word;
    logic [3:0]         scan_bits;

    mmff_group #(.WIDTH(WIDTH)) dut (
        .clock          (clock),
        .global_reset_n (global_reset_n),
        .config_enable  (config_enable),
        .ccff_head      (ccff_head),
        .ccff_tail      (ccff_tail),
        .cfg_loaded     (cfg_loaded),
        .scan_mode      (scan_mode),
        .scan_enable    (scan_enable),
        .scan_in        (scan_in),
        .scan_out       (scan_out),
        .d              (d),
        .r              (r),
        .e              (e),
        .q_out          (q_out)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        global_reset_n = 1'b0;
        config_enable  = 1'b0;
        ccff_head      = 1'b0;
        scan_mode      = 1'b0;
        scan_enable    = 1'b0;
        scan_in        = 1'b0;
        d = WIDTH'($urandom);
        r = WIDTH'($urandom);
        e = WIDTH'($urandom);
        tick();
        d = WIDTH'($urandom);
        tick();
        chk("rst_q_out", 32'(q_out), 32'h0);
        chk("rst_scan_out", 32'(scan_out), 32'h0);
        chk("rst_tail", 32'(ccff_tail), 32'h0);
        chk("rst_loaded", 32'(cfg_loaded), 32'h0);

        d = '0; r = '0; e = '0;
        global_reset_n = 1'b1;
        tick();
        chk("post_rst_q_out", 32'(q_out), 32'h0);

        // ch3=0, ch2=0, ch1=BYPASS|INV, ch0=EN_USE|RST_USE
        word = {5'b00000, 5'b00000, 5'b11000, 5'b00011};
        config_enable = 1'b1;
        for (int t = 0; t < CFG_LEN; t++) begin
            ccff_head = word[CFG_LEN-1-t];
            tick();
            if (t == CFG_LEN - 2)
                chk("loaded_edge19", 32'(cfg_loaded), 32'h0);
        end
        chk("loaded_edge20", 32'(cfg_loaded), 32'h1);
        config_enable = 1'b0;
        ccff_head     = 1'b0;

        d = 4'b0001; e = 4'b0000; r = 4'b0000;
        tick();
        chk("en_hold", 32'(q_out), 32'b0010);
        e = 4'b0001;
        tick();
        chk("en_load", 32'(q_out), 32'b0011);
        r = 4'b0001; e = 4'b0000;
        tick();
        chk("sync_rst", 32'(q_out), 32'b0010);

        r = 4'b0000; d = 4'b0010;
        #1;
        chk("bypass_comb", 32'(q_out), 32'b0000);
        tick();
        chk("bypass_reg", 32'(q_out), 32'b0000);

        scan_mode = 1'b1;
        #1;
        chk("scan_mode_raw", 32'(q_out), 32'b0010);
        d = 4'b0000;
        #1;
        chk("scan_mode_late", 32'(q_out), 32'b0010);
        tick();
        chk("scan_mode_load0", 32'(q_out), 32'b0000);
        d = 4'b0110;
        tick();
        chk("scan_mode_load1", 32'(q_out), 32'b0110);

        scan_bits   = 4'b1011;
        scan_enable = 1'b1;
        for (int t = 0; t < 4; t++) begin
            scan_in = scan_bits[3-t];
            tick();
        end
        chk("scan_q", 32'(q_out), 32'b1011);
        chk("scan_out", 32'(scan_out), 32'h1);
        config_enable = 1'b1;
        scan_in = 1'b0;
        tick();
        chk("cfg_over_scan", 32'(q_out), 32'b1011);
        chk("cfg_restart_cnt", 32'(cfg_loaded), 32'h0);
        config_enable = 1'b0;
        scan_enable   = 1'b0;
        tick();

        config_enable = 1'b1;
        for (int t = 0; t < 10; t++) tick();
        chk("partial_10", 32'(cfg_loaded), 32'h0);
        config_enable = 1'b0;
        tick();
        tick();
        chk("partial_hold", 32'(cfg_loaded), 32'h0);

        config_enable = 1'b1;
        for (int t = 0; t < CFG_LEN; t++) begin
            ccff_head = (t == 0);
            tick();
            if (t == CFG_LEN - 2)
                chk("rerise_19", 32'(cfg_loaded), 32'h0);
        end
        chk("rerise_20", 32'(cfg_loaded), 32'h1);
        chk("tail_first_bit", 32'(ccff_tail), 32'h1);
        ccff_head = 1'b0;
        tick();
        chk("cnt_saturate", 32'(cfg_loaded), 32'h1);

        global_reset_n = 1'b0;
        #1;
        chk("async_loaded", 32'(cfg_loaded), 32'h0);
        chk("async_tail", 32'(ccff_tail), 32'h0);
        chk("async_scan_out", 32'(scan_out), 32'h0);
        tick();
        global_reset_n = 1'b1;
        for (int t = 0; t < CFG_LEN; t++) begin
            tick();
            if (t == CFG_LEN - 2)
                chk("reload_19", 32'(cfg_loaded), 32'h0);
        end
        chk("reload_20", 32'(cfg_loaded), 32'h1);
        config_enable = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
